io_port_hub: RTL and testbench

Parametrised CPU I/O port controller placed between the `cpu` port bus and external devices. It replaces direct wiring of port data with per-port buffered channels. Each port has a CPU→device TX FIFO and a device→CPU RX FIFO, valid/ready handshakes on the device side and sticky overflow/underflow error flags. Port count, data width and buffer depth are parameters, so a single block serves every CPU configuration.

---
 rtl/io_port_hub_pkg.sv | 15 +
 rtl/port_fifo.sv | 61 ++++++
 rtl/io_port_hub.sv | 107 ++++++++++
 tb/tb_io_port_hub.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/io_port_hub_pkg.sv
// io_port_hub_pkg: shared constants and types for the I/O port hub.
//   DEF_PORT_COUNT / DEF_DATA_W / DEF_DEPTH : default parameter values
//   err_idx_e : bit index of each sticky error flag within a port's error pair
package io_port_hub_pkg;

  localparam int DEF_PORT_COUNT = 4;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_DEPTH      = 4;

  typedef enum logic {
    ERR_OVF = 1'b0,
    ERR_UDF = 1'b1
  } err_idx_e;

endpackage

// File: rtl/port_fifo.sv
// port_fifo: single-clock first-word-fall-through FIFO, one per direction per port.
//   clk, rst          : clock, async active-high reset (pointers/count only)
//   wr_en, wr_data    : push request; accepted when not full, or when full and
//                       a pop fires in the same cycle
//   rd_en             : pop request; ignored when empty
//   rd_data           : head entry, forced to 0 while empty
//   full, empty       : derived from the registered count only
module port_fifo
  import io_port_hub_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int DEPTH  = DEF_DEPTH
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              full,
  output logic              empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem [DEPTH];
  logic [PW-1:0]     wptr, rptr;
  logic [CW-1:0]     count;
  logic              wr_ok, rd_ok;

  assign empty   = (count == '0);
  assign full    = (count == CW'(DEPTH));
  assign rd_ok   = rd_en & ~empty;
  // When full, the slot being written is the one being popped this cycle; the
  // head is read combinationally before the edge, so the overwrite is safe.
  assign wr_ok   = wr_en & (~full | rd_ok);
  assign rd_data = empty ? '0 : mem[rptr];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr  <= '0;
      rptr  <= '0;
      count <= '0;
    end else begin
      if (wr_ok) wptr <= wptr + PW'(1);
      if (rd_ok) rptr <= rptr + PW'(1);
      case ({wr_ok, rd_ok})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: ;
      endcase
    end
  end

  // Storage is not reset: contents are don't-care once pointers clear.
  always_ff @(posedge clk) begin
    if (wr_ok) mem[wptr] <= wr_data;
  end

endmodule

// File: rtl/io_port_hub.sv
// io_port_hub: per-port buffered channels between the CPU port bus and devices.
// Each port owns a CPU->device TX FIFO and a device->CPU RX FIFO, valid/ready
// device handshakes and sticky overflow/underflow flags.
//   cpu_wr/cpu_wr_data        : TX push (dropped + err_ovf when full w/o pop)
//   cpu_rd/cpu_rd_data        : RX pop / FWFT head (err_udf on empty read)
//   rx_avail, tx_full         : RX non-empty, TX full
//   dev_tx_valid/ready/data   : device side of TX
//   dev_rx_valid/ready/data   : device side of RX (ready from registered count)
//   err_ovf, err_udf, err_clr : sticky flags; a set beats a same-cycle clear
// Optional: IO_PORT_HUB_LOOPBACK_EN adds `loopback`, routing TX head into RX
// of the same port and masking dev_tx_valid / dev_rx_ready.
module io_port_hub
  import io_port_hub_pkg::*;
#(
  parameter int PORT_COUNT = DEF_PORT_COUNT,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int DEPTH      = DEF_DEPTH
) (
  input  logic                         clk,
  input  logic                         rst,
`ifdef IO_PORT_HUB_LOOPBACK_EN
  input  logic [PORT_COUNT-1:0]        loopback,
`endif
  input  logic [PORT_COUNT-1:0]        cpu_wr,
  input  logic [PORT_COUNT*DATA_W-1:0] cpu_wr_data,
  input  logic [PORT_COUNT-1:0]        cpu_rd,
  output logic [PORT_COUNT*DATA_W-1:0] cpu_rd_data,
  output logic [PORT_COUNT-1:0]        rx_avail,
  output logic [PORT_COUNT-1:0]        tx_full,
  output logic [PORT_COUNT-1:0]        dev_tx_valid,
  input  logic [PORT_COUNT-1:0]        dev_tx_ready,
  output logic [PORT_COUNT*DATA_W-1:0] dev_tx_data,
  input  logic [PORT_COUNT-1:0]        dev_rx_valid,
  output logic [PORT_COUNT-1:0]        dev_rx_ready,
  input  logic [PORT_COUNT*DATA_W-1:0] dev_rx_data,
  output logic [PORT_COUNT-1:0]        err_ovf,
  output logic [PORT_COUNT-1:0]        err_udf,
  input  logic [PORT_COUNT-1:0]        err_clr
);

  logic [PORT_COUNT-1:0][DATA_W-1:0] tx_wdata, tx_head, rx_in, rx_head;
  logic [PORT_COUNT-1:0][1:0]        err_set, err_q;
  logic [PORT_COUNT-1:0]             lb;

`ifdef IO_PORT_HUB_LOOPBACK_EN
  assign lb = loopback;
`else
  assign lb = '0;
`endif

  assign tx_wdata    = cpu_wr_data;
  assign rx_in       = dev_rx_data;
  assign dev_tx_data = tx_head;
  assign cpu_rd_data = rx_head;

  for (genvar p = 0; p < PORT_COUNT; p++) begin : g_port
    logic              tx_empty, tx_full_i, rx_empty, rx_full_i;
    logic              lb_move, tx_pop, rx_push;
    logic [DATA_W-1:0] rx_wdata;

    // Loopback transfer only when both sides allow it; the path is purely
    // combinational per cycle, so toggling loopback cannot lose or repeat words.
    assign lb_move         = lb[p] & ~tx_empty & ~rx_full_i;
    assign dev_tx_valid[p] = ~lb[p] & ~tx_empty;
    assign dev_rx_ready[p] = ~lb[p] & ~rx_full_i;
    assign tx_pop   = lb[p] ? lb_move : (dev_tx_valid[p] & dev_tx_ready[p]);
    assign rx_push  = lb[p] ? lb_move : (dev_rx_valid[p] & dev_rx_ready[p]);
    assign rx_wdata = lb[p] ? tx_head[p] : rx_in[p];

    assign tx_full[p]  = tx_full_i;
    assign rx_avail[p] = ~rx_empty;

    port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_tx (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (cpu_wr[p]),
      .wr_data (tx_wdata[p]),
      .rd_en   (tx_pop),
      .rd_data (tx_head[p]),
      .full    (tx_full_i),
      .empty   (tx_empty)
    );

    port_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_rx (
      .clk     (clk),
      .rst     (rst),
      .wr_en   (rx_push),
      .wr_data (rx_wdata),
      .rd_en   (cpu_rd[p]),
      .rd_data (rx_head[p]),
      .full    (rx_full_i),
      .empty   (rx_empty)
    );

    assign err_set[p][ERR_OVF] = cpu_wr[p] & tx_full_i & ~tx_pop;
    assign err_set[p][ERR_UDF] = cpu_rd[p] & rx_empty;

    always_ff @(posedge clk or posedge rst) begin
      if (rst) err_q[p] <= '0;
      else     err_q[p] <= err_set[p] | (err_q[p] & {2{~err_clr[p]}});
    end

    assign err_ovf[p] = err_q[p][ERR_OVF];
    assign err_udf[p] = err_q[p][ERR_UDF];
  end

endmodule

// File: tb/tb_io_port_hub.sv
module tb_io_port_hub;
  localparam int PC = 4;
  localparam int DW = 16;
  localparam int DP = 4;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic [PC-1:0]     cpu_wr = '0, cpu_rd = '0, dev_tx_ready = '0, dev_rx_valid = '0, err_clr = '0;
  logic [PC*DW-1:0]  cpu_wr_data = '0, dev_rx_data = '0;
  logic [PC*DW-1:0]  cpu_rd_data, dev_tx_data;
  logic [PC-1:0]     rx_avail, tx_full, dev_tx_valid, dev_rx_ready, err_ovf, err_udf;
`ifdef IO_PORT_HUB_LOOPBACK_EN
  logic [PC-1:0]     loopback = '0;
`endif

  int checks = 0;
  int failures = 0;

  io_port_hub #(.PORT_COUNT(PC), .DATA_W(DW), .DEPTH(DP)) dut (
    .clk(clk), .rst(rst),
`ifdef IO_PORT_HUB_LOOPBACK_EN
    .loopback(loopback),
`endif
    .cpu_wr(cpu_wr), .cpu_wr_data(cpu_wr_data), .cpu_rd(cpu_rd), .cpu_rd_data(cpu_rd_data),
    .rx_avail(rx_avail), .tx_full(tx_full),
    .dev_tx_valid(dev_tx_valid), .dev_tx_ready(dev_tx_ready), .dev_tx_data(dev_tx_data),
    .dev_rx_valid(dev_rx_valid), .dev_rx_ready(dev_rx_ready), .dev_rx_data(dev_rx_data),
    .err_ovf(err_ovf), .err_udf(err_udf), .err_clr(err_clr)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          port;
    logic        wr;  logic [DW-1:0] wd; logic rd; logic txr;
    logic        rxv; logic [DW-1:0] rxd; logic clr;
    logic        txv; logic [DW-1:0] txd; logic txf; logic rxa;
    logic [DW-1:0] rdd; logic ovf; logic udf;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input int port, input logic wr, input logic [DW-1:0] wd,
                              input logic rd, input logic txr, input logic rxv,
                              input logic [DW-1:0] rxd, input logic clr,
                              input logic txv, input logic [DW-1:0] txd, input logic txf,
                              input logic rxa, input logic [DW-1:0] rdd,
                              input logic ovf, input logic udf);
    vec_t v;
    v.port = port; v.wr = wr; v.wd = wd; v.rd = rd; v.txr = txr; v.rxv = rxv;
    v.rxd = rxd; v.clr = clr; v.txv = txv; v.txd = txd; v.txf = txf; v.rxa = rxa;
    v.rdd = rdd; v.ovf = ovf; v.udf = udf;
    return v;
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s step=%0d got=%0h expected=%0h", name, idx, act, exp);
    end
  endtask

  task automatic idle();
    cpu_wr = '0; cpu_rd = '0; dev_tx_ready = '0; dev_rx_valid = '0; err_clr = '0;
    cpu_wr_data = '0; dev_rx_data = '0;
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic apply(input vec_t v);
    idle();
    cpu_wr[v.port] = v.wr;
    cpu_wr_data[v.port*DW +: DW] = v.wd;
    cpu_rd[v.port] = v.rd;
    dev_tx_ready[v.port] = v.txr;
    dev_rx_valid[v.port] = v.rxv;
    dev_rx_data[v.port*DW +: DW] = v.rxd;
    err_clr[v.port] = v.clr;
  endtask

  initial begin
    // port, wr, wd, rd, txr, rxv, rxd, clr | txv, txd, txf, rxa, rdd, ovf, udf
    vecs.push_back(mk(0, 1, 16'h000A, 0, 1, 0, 0, 0,  1, 16'h000A, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 1, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h1, 0, 0, 0, 0, 0,     1, 16'h1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h2, 0, 0, 0, 0, 0,     1, 16'h1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h3, 0, 0, 0, 0, 0,     1, 16'h1, 0, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h4, 0, 0, 0, 0, 0,     1, 16'h1, 1, 0, 0, 0, 0));
    vecs.push_back(mk(1, 1, 16'h5, 0, 0, 0, 0, 0,     1, 16'h1, 1, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0,         1, 16'h2, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0,         1, 16'h3, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0,         1, 16'h4, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 1, 0, 0, 0,         0, 0, 0, 0, 0, 1, 0));
    vecs.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 0, 0, 0, 1, 16'h00AA, 0,  0, 0, 0, 1, 16'h00AA, 0, 0));
    vecs.push_back(mk(2, 0, 0, 0, 0, 1, 16'h00BB, 0,  0, 0, 0, 1, 16'h00AA, 0, 0));
    vecs.push_back(mk(2, 0, 0, 1, 0, 0, 0, 0,         0, 0, 0, 1, 16'h00BB, 0, 0));
    vecs.push_back(mk(2, 0, 0, 1, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(2, 0, 0, 1, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(2, 0, 0, 1, 0, 0, 0, 1,         0, 0, 0, 0, 0, 0, 1));
    vecs.push_back(mk(2, 0, 0, 0, 0, 0, 0, 1,         0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(3, 1, 16'h11, 0, 0, 0, 0, 0,    1, 16'h11, 0, 0, 0, 0, 0));
    vecs.push_back(mk(3, 1, 16'h12, 0, 0, 0, 0, 0,    1, 16'h11, 0, 0, 0, 0, 0));
    vecs.push_back(mk(3, 1, 16'h13, 0, 0, 0, 0, 0,    1, 16'h11, 0, 0, 0, 0, 0));
    vecs.push_back(mk(3, 1, 16'h14, 0, 0, 0, 0, 0,    1, 16'h11, 1, 0, 0, 0, 0));
    vecs.push_back(mk(3, 1, 16'h15, 0, 1, 0, 0, 0,    1, 16'h12, 1, 0, 0, 0, 0));
    vecs.push_back(mk(3, 0, 0, 0, 1, 0, 0, 0,         1, 16'h13, 0, 0, 0, 0, 0));
    vecs.push_back(mk(3, 0, 0, 0, 1, 0, 0, 0,         1, 16'h14, 0, 0, 0, 0, 0));
    vecs.push_back(mk(3, 0, 0, 0, 1, 0, 0, 0,         1, 16'h15, 0, 0, 0, 0, 0));
    vecs.push_back(mk(3, 0, 0, 0, 1, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0));
    vecs.push_back(mk(0, 0, 0, 0, 0, 1, 16'h31, 0,    0, 0, 0, 1, 16'h31, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 1, 16'h32, 0,    0, 0, 0, 1, 16'h32, 0, 0));
    vecs.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0,         0, 0, 0, 0, 0, 0, 0));

    // Reset state
    #2;
    chk("rst_tx_valid", 0, dev_tx_valid, 0);
    chk("rst_rx_ready", 0, dev_rx_ready, 4'hF);
    chk("rst_rx_avail", 0, rx_avail, 0);
    chk("rst_tx_full", 0, tx_full, 0);
    chk("rst_rd_data", 0, cpu_rd_data, 0);
    chk("rst_tx_data", 0, dev_tx_data, 0);
    chk("rst_flags", 0, {err_ovf, err_udf}, 0);
    step(); step();
    rst = 1'b0;
    step();

    foreach (vecs[i]) begin
      int p;
      p = vecs[i].port;
      apply(vecs[i]);
      step();
      chk("tx_valid", i, dev_tx_valid[p], vecs[i].txv);
      chk("tx_data", i, dev_tx_data[p*DW +: DW], vecs[i].txd);
      chk("tx_full", i, tx_full[p], vecs[i].txf);
      chk("rx_avail", i, rx_avail[p], vecs[i].rxa);
      chk("rd_data", i, cpu_rd_data[p*DW +: DW], vecs[i].rdd);
      chk("err_ovf", i, err_ovf[p], vecs[i].ovf);
      chk("err_udf", i, err_udf[p], vecs[i].udf);
    end
    idle();

    // RX full on port 1: ready drops, then a same-cycle read must not reopen it
    for (int k = 0; k < 4; k++) begin
      dev_rx_valid[1] = 1'b1;
      dev_rx_data[1*DW +: DW] = 16'h21 + 16'(k);
      step();
    end
    idle();
    chk("rx_full_ready", 100, dev_rx_ready[1], 0);
    dev_rx_valid[1] = 1'b1;
    dev_rx_data[1*DW +: DW] = 16'h25;
    cpu_rd[1] = 1'b1;
    #1;
    chk("rx_ready_no_comb", 101, dev_rx_ready[1], 0);
    step();
    idle();
    chk("rx_ready_after_pop", 102, dev_rx_ready[1], 1);
    chk("rx_head_after_pop", 102, cpu_rd_data[1*DW +: DW], 16'h22);
    cpu_rd[1] = 1'b1;
    step();
    chk("rx_drain_23", 103, cpu_rd_data[1*DW +: DW], 16'h23);
    step();
    chk("rx_drain_24", 104, cpu_rd_data[1*DW +: DW], 16'h24);
    step();
    idle();
    chk("rx_drain_empty", 105, rx_avail[1], 0);
    chk("rx_no_udf", 105, err_udf[1], 0);

`ifdef IO_PORT_HUB_LOOPBACK_EN
    loopback[0] = 1'b1;
    cpu_wr[0] = 1'b1;
    cpu_wr_data[0*DW +: DW] = 16'h1234;
    step();
    idle();
    chk("lb_tx_valid_masked", 110, dev_tx_valid[0], 0);
    chk("lb_rx_ready_masked", 110, dev_rx_ready[0], 0);
    step();
    chk("lb_rd_data", 111, cpu_rd_data[0*DW +: DW], 16'h1234);
    chk("lb_tx_valid_masked2", 111, dev_tx_valid[0], 0);
    cpu_rd[0] = 1'b1;
    step();
    idle();
    loopback[0] = 1'b0;
    chk("lb_drained", 112, rx_avail[0], 0);
`endif

    // Async reset with 3 words queued on port 3 and a pending flag on port 2
    for (int k = 0; k < 3; k++) begin
      cpu_wr[3] = 1'b1;
      cpu_wr_data[3*DW +: DW] = 16'h41 + 16'(k);
      step();
    end
    idle();
    cpu_rd[2] = 1'b1;
    step();
    idle();
    chk("pre_rst_tx_valid", 120, dev_tx_valid[3], 1);
    chk("pre_rst_udf", 120, err_udf[2], 1);
    #2;
    rst = 1'b1;
    #1;
    chk("async_rst_tx_valid", 121, dev_tx_valid[3], 0);
    chk("async_rst_flags", 121, {err_ovf, err_udf}, 0);
    chk("async_rst_rx_ready", 121, dev_rx_ready, 4'hF);
    chk("async_rst_tx_data", 121, dev_tx_data, 0);
    step();
    rst = 1'b0;
    step();
    chk("post_rst_tx_valid", 122, dev_tx_valid, 0);
    chk("post_rst_tx_full", 122, tx_full, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
